panel_scan_controller: RTL and testbench

//   Timing master directly upstream of the panel driver. Walks the cube's rows (layers) and, for each row,

---
 rtl/panel_scan_pkg.sv | 26 ++
 rtl/panel_scan_controller.sv | 166 ++++++++++++++++
 tb/tb_panel_scan_controller.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/panel_scan_pkg.sv
// Shared types and helpers for the cube panel scan controller.
// State encoding, row/PWM field widths and the layer one-hot decode.
package panel_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ROW_SETUP,
        LOAD_BRIGHT,
        SHIFT,
        LATCH,
        HOLD,
        ROW_END,
        DEAD
    } state_t;

    localparam int ROW_W    = 4;
    localparam int MAX_ROWS = 1 << ROW_W;
    localparam int PWM_W    = 8;

    function automatic logic [MAX_ROWS-1:0] row_onehot(
        input logic [ROW_W-1:0] r
    );
        return MAX_ROWS'(1) << r;
    endfunction

endpackage

// File: rtl/panel_scan_controller.sv
// Row/PWM timing master feeding all panel drivers of one cube.
// Define PANEL_SCAN_DEADTIME_EN to insert blanking cycles between rows.
module panel_scan_controller
    import panel_scan_pkg::*;
#(
    parameter int NUM_ROWS    = 16,
    parameter int SHIFT_LEN   = 16,
    parameter int PWM_BITS    = PWM_W,
    parameter int HOLD_CYCLES = 8,
    parameter int RAM_LATENCY = 2,
    parameter int DEAD_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    output logic [ROW_W-1:0]    active_row_addr,
    output logic [PWM_BITS-1:0] pwm_time,
    output logic                shift,
    output logic                load_led_vals,
    output logic                load_brightness,
    output logic [NUM_ROWS-1:0] layer_enable,
    output logic                frame_start,
    output logic                busy
);

    // One shared down-counter covers every timed state, so size it for the longest.
    localparam int M1      = (SHIFT_LEN > HOLD_CYCLES) ? SHIFT_LEN : HOLD_CYCLES;
    localparam int M2      = (M1 > RAM_LATENCY) ? M1 : RAM_LATENCY;
    localparam int CNT_MAX = (M2 > DEAD_CYCLES) ? M2 : DEAD_CYCLES;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(RAM_LATENCY - 1);
    localparam logic [CNT_W-1:0] LD_SHIFT = CNT_W'(SHIFT_LEN - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYCLES - 1);
`ifdef PANEL_SCAN_DEADTIME_EN
    localparam logic [CNT_W-1:0] LD_DEAD  = CNT_W'(DEAD_CYCLES - 1);
`endif
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

    state_t                state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [ROW_W-1:0]      row, row_n, row_adv;
    logic [PWM_BITS-1:0]   pwm, pwm_n;
    logic                  lit, lit_n;
    logic                  fs, fs_n;
    logic                  last;
    logic [MAX_ROWS-1:0]   row_oh;

    assign last    = (cnt == '0);
    assign row_adv = (row == LAST_ROW) ? '0 : row + ROW_W'(1);

    // State, counter and scan position registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            row   <= '0;
            pwm   <= '0;
            lit   <= 1'b0;
            fs    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            row   <= row_n;
            pwm   <= pwm_n;
            lit   <= lit_n;
            fs    <= fs_n;
        end
    end

    // Next-state, counter reloads and row/PWM stepping.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        row_n   = row;
        pwm_n   = pwm;
        lit_n   = lit;
        fs_n    = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_n = ROW_SETUP;
                    cnt_n   = LD_SETUP;
                    row_n   = '0;
                    pwm_n   = '0;
                    fs_n    = 1'b1;
                end
            end
            ROW_SETUP: begin
                if (last) state_n = LOAD_BRIGHT;
                else      cnt_n   = cnt - CNT_W'(1);
            end
            LOAD_BRIGHT: begin
                state_n = SHIFT;
                cnt_n   = LD_SHIFT;
            end
            SHIFT: begin
                if (last) state_n = LATCH;
                else      cnt_n   = cnt - CNT_W'(1);
            end
            LATCH: begin
                state_n = HOLD;
                cnt_n   = LD_HOLD;
                lit_n   = 1'b1;
            end
            HOLD: begin
                if (!last) begin
                    cnt_n = cnt - CNT_W'(1);
                end else if (pwm == {PWM_BITS{1'b1}}) begin
                    state_n = ROW_END;
                    lit_n   = 1'b0;
                    pwm_n   = '0;
                end else begin
                    state_n = SHIFT;
                    cnt_n   = LD_SHIFT;
                    pwm_n   = pwm + PWM_BITS'(1);
                end
            end
            ROW_END: begin
`ifdef PANEL_SCAN_DEADTIME_EN
                state_n = DEAD;
                cnt_n   = LD_DEAD;
                row_n   = row_adv;
`else
                if (enable) begin
                    state_n = ROW_SETUP;
                    cnt_n   = LD_SETUP;
                    row_n   = row_adv;
                    fs_n    = (row_adv == '0);
                end else begin
                    state_n = IDLE;
                    row_n   = '0;
                end
`endif
            end
            DEAD: begin
`ifdef PANEL_SCAN_DEADTIME_EN
                if (!last) begin
                    cnt_n = cnt - CNT_W'(1);
                end else if (enable) begin
                    state_n = ROW_SETUP;
                    cnt_n   = LD_SETUP;
                    fs_n    = (row == '0);
                end else begin
                    state_n = IDLE;
                    row_n   = '0;
                end
`else
                state_n = IDLE;
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    assign row_oh          = row_onehot(row);
    assign active_row_addr = row;
    assign pwm_time        = pwm;
    assign shift           = (state == SHIFT);
    assign load_led_vals   = (state == LATCH);
    assign load_brightness = (state == LOAD_BRIGHT);
    assign layer_enable    = lit ? row_oh[NUM_ROWS-1:0] : '0;
    assign frame_start     = fs;
    assign busy            = (state != IDLE);

endmodule

// File: tb/tb_panel_scan_controller.sv
// Randomized bench for panel_scan_controller against a row-schedule model.
// Uses a reduced PWM width so full frames fit in a short run.
module tb_panel_scan_controller;

    localparam int NR   = 16;
    localparam int SL   = 16;
    localparam int PW   = 4;
    localparam int HC   = 8;
    localparam int RL   = 2;
    localparam int DC   = 4;
    localparam int STEP = SL + 1 + HC;
    localparam int NSTP = 1 << PW;
    localparam int BODY = RL + 1 + NSTP * STEP;
`ifdef PANEL_SCAN_DEADTIME_EN
    localparam int RLEN = BODY + 1 + DC;
`else
    localparam int RLEN = BODY + 1;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [3:0]    active_row_addr;
    logic [PW-1:0] pwm_time;
    logic          shift;
    logic          load_led_vals;
    logic          load_brightness;
    logic [NR-1:0] layer_enable;
    logic          frame_start;
    logic          busy;

    panel_scan_controller #(
        .NUM_ROWS    (NR),
        .SHIFT_LEN   (SL),
        .PWM_BITS    (PW),
        .HOLD_CYCLES (HC),
        .RAM_LATENCY (RL),
        .DEAD_CYCLES (DC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .active_row_addr (active_row_addr),
        .pwm_time        (pwm_time),
        .shift           (shift),
        .load_led_vals   (load_led_vals),
        .load_brightness (load_brightness),
        .layer_enable    (layer_enable),
        .frame_start     (frame_start),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // model: running flag, row, cycle offset within the row period
    bit m_run = 0;
    int m_row = 0;
    int m_t   = 0;
    bit m_fs  = 0;

    int lat_cnt = 0;
    int sh_cnt  = 0;
    int fs_q[$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit in_shift();
        int u;
        if (!m_run || m_t <= RL || m_t >= BODY) return 0;
        u = m_t - RL - 1;
        return (u % STEP) < SL;
    endfunction

    task automatic compare();
        logic        e_sh, e_ll, e_lb;
        logic [31:0] e_pwm, e_lay;
        int          u;
        e_sh = 0; e_ll = 0; e_lb = 0; e_pwm = 0; e_lay = 0;
        if (m_run) begin
            if (m_t == RL) e_lb = 1;
            if (m_t > RL && m_t < BODY) begin
                u     = m_t - RL - 1;
                e_pwm = 32'(u / STEP);
                e_sh  = (u % STEP) < SL;
                e_ll  = (u % STEP) == SL;
                if (m_t >= RL + SL + 2) e_lay = 32'(1) << m_row;
            end
        end
        check("shift", 32'(shift), 32'(e_sh));
        check("load_led_vals", 32'(load_led_vals), 32'(e_ll));
        check("load_brightness", 32'(load_brightness), 32'(e_lb));
        check("frame_start", 32'(frame_start), 32'(m_fs));
        check("busy", 32'(busy), 32'(m_run));
        check("row", 32'(active_row_addr), 32'(m_row));
        check("pwm_time", 32'(pwm_time), e_pwm);
        check("layer_enable", 32'(layer_enable), e_lay);
        if (frame_start) fs_q.push_back(cyc);
        if (!m_run || m_t == 0) begin
            lat_cnt = 0;
            sh_cnt  = 0;
        end
        lat_cnt += int'(load_led_vals);
        sh_cnt  += int'(shift);
        if (m_run && m_t == BODY) begin
            check("row_latches", 32'(lat_cnt), 32'(NSTP));
            check("row_shifts", 32'(sh_cnt), 32'(NSTP * SL));
        end
    endtask

    task automatic cycle(input bit en, input bit rst);
        enable = en;
        reset  = rst;
        if (rst) begin
            m_run = 0; m_row = 0; m_t = 0; m_fs = 0;
        end else if (!m_run) begin
            m_fs = en;
            if (en) begin
                m_run = 1; m_row = 0; m_t = 0;
            end
        end else begin
            m_fs = 0;
            if (m_t == BODY) m_row = (m_row + 1) % NR;
            if (m_t == RLEN - 1) begin
                m_t = 0;
                if (!en) begin
                    m_run = 0; m_row = 0;
                end else begin
                    m_fs = (m_row == 0);
                end
            end else begin
                m_t++;
            end
        end
        @(negedge clk);
        cyc++;
        compare();
    endtask

    initial begin
        bit en;
        int guard;

        // reset then continuous scan through more than one frame
        repeat (3) cycle(1'b0, 1'b1);
        fs_q.delete();
        for (int i = 0; i < NR * RLEN + 40; i++) cycle(1'b1, 1'b0);
        check("first_frame_start", 32'(fs_q.size() > 0 ? fs_q[0] : -1), 32'd4);
        check("frame_period",
              32'(fs_q.size() > 1 ? fs_q[1] - fs_q[0] : -1), 32'(NR * RLEN));

        // drop enable mid row 5; row must finish then go idle
        repeat (2) cycle(1'b0, 1'b1);
        guard = 0;
        while (!(m_run && m_row == 5 && m_t == 50) && guard < 7 * RLEN) begin
            cycle(1'b1, 1'b0);
            guard++;
        end
        check("reach_row5", 32'(m_row), 32'd5);
        for (int i = 0; i < RLEN + 10; i++) cycle(1'b0, 1'b0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_layer", 32'(layer_enable), 32'd0);
        check("idle_row", 32'(active_row_addr), 32'd0);
        for (int i = 0; i < 2 * RLEN; i++) cycle(1'b1, 1'b0);

        // reset deep inside a shift burst of row 1
        repeat (2) cycle(1'b0, 1'b1);
        guard = 0;
        while (!(m_row == 1 && in_shift() && m_t > RL + 3 * STEP)
               && guard < 3 * RLEN) begin
            cycle(1'b1, 1'b0);
            guard++;
        end
        check("pre_rst_shift", 32'(shift), 32'd1);
        cycle(1'b1, 1'b1);
        check("rst_shift", 32'(shift), 32'd0);
        check("rst_layer", 32'(layer_enable), 32'd0);
        check("rst_pwm", 32'(pwm_time), 32'd0);
        check("rst_row", 32'(active_row_addr), 32'd0);

        // random enable toggling and occasional resets
        en = 1;
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(399) == 0) en = ~en;
            cycle(en, $urandom_range(3999) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
